// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational reads, two prioritised writes, and a
// one-entry-per-cycle clear sweep. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg_rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable_2,
  input  logic [ADDR_WIDTH-1:0] write_reg_2,
  input  logic [DATA_WIDTH-1:0] write_data_2,
  input  logic                  clear_req,
  output logic                  clear_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep_cnt;
  logic [ADDR_WIDTH-1:0] w_sweep_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic w_idle;
  logic w_we1_ok;
  logic w_we2_ok;

  // Accepted writes: only when idle and out of reset, never to a hardwired zero entry,
  // and port 2 yields to port 1 on an index collision.
  assign w_idle   = reset_n && (r_state == ST_IDLE);
  assign w_we1_ok = write_enable && w_idle && !(ZERO_EN && (write_reg_rd == '0));
  assign w_we2_ok = write_enable_2 && w_idle && !(ZERO_EN && (write_reg_2 == '0))
                    && !(write_enable && (write_reg_2 == write_reg_rd));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_cnt_nxt = r_sweep_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt     = ST_CLEAR;
          w_sweep_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        w_sweep_cnt_nxt = r_sweep_cnt + 1'b1;
        if (r_sweep_cnt == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_regs[r_sweep_cnt] <= '0;
    end else begin
      if (w_we2_ok) r_regs[write_reg_2]  <= write_data_2;
      if (w_we1_ok) r_regs[write_reg_rd] <= write_data;
    end
  end

  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  always_comb begin
    w_rd_a = r_regs[read_reg_a];
    w_rd_b = r_regs[read_reg_b];
`ifdef REGFILE_BYPASS_EN
    // Port 2 first so a matching port-1 write overrides it.
    if (w_we2_ok && (write_reg_2 == read_reg_a))  w_rd_a = write_data_2;
    if (w_we1_ok && (write_reg_rd == read_reg_a)) w_rd_a = write_data;
    if (w_we2_ok && (write_reg_2 == read_reg_b))  w_rd_b = write_data_2;
    if (w_we1_ok && (write_reg_rd == read_reg_b)) w_rd_b = write_data;
`endif
    if (ZERO_EN && (read_reg_a == '0)) w_rd_a = '0;
    if (ZERO_EN && (read_reg_b == '0)) w_rd_b = '0;
  end

  assign read_data_a = w_rd_a;
  assign read_data_b = w_rd_b;
  assign clear_busy  = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised scoreboard bench for register_file_mp: a behavioural array model predicts
// every cycle's read data and clear_busy; a negedge monitor pops and compares.
module tb_register_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int ZR    = 1;
  localparam int EW    = 2 * DW + 1;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] read_reg_a, read_reg_b;
  logic [DW-1:0] read_data_a, read_data_b;
  logic          write_enable, write_enable_2;
  logic [AW-1:0] write_reg_rd, write_reg_2;
  logic [DW-1:0] write_data, write_data_2;
  logic          clear_req;
  logic          clear_busy;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset_n(reset_n),
    .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .write_enable(write_enable), .write_reg_rd(write_reg_rd), .write_data(write_data),
    .write_enable_2(write_enable_2), .write_reg_2(write_reg_2), .write_data_2(write_data_2),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [DEPTH];
  int            sweep_left;
  int            cyc;

  logic [EW-1:0] exp_q [$];
  logic          chk_valid;
  int            n_checks;
  int            n_pass;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (ZR != 0 && idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reset_n && sweep_left == 0) begin
      if (write_enable && write_reg_rd == idx && !(ZR != 0 && idx == 0)) return write_data;
      if (write_enable_2 && write_reg_2 == idx) return write_data_2;
    end
`endif
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    sweep_left = 0;
  endtask

  task automatic model_edge();
    if (sweep_left > 0) begin
      mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (write_enable_2 && !(ZR != 0 && write_reg_2 == 0)
          && !(write_enable && write_reg_rd == write_reg_2))
        mem[write_reg_2] = write_data_2;
      if (write_enable && !(ZR != 0 && write_reg_rd == 0))
        mem[write_reg_rd] = write_data;
      if (clear_req) sweep_left = DEPTH;
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: apply inputs, predict this cycle, advance the model.
  task automatic step(input logic rst_n, input logic w1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic w2, input logic [AW-1:0] a2,
                      input logic [DW-1:0] d2, input logic clr,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    reset_n        = rst_n;
    write_enable   = w1;  write_reg_rd = a1; write_data   = d1;
    write_enable_2 = w2;  write_reg_2  = a2; write_data_2 = d2;
    clear_req      = clr;
    read_reg_a     = ra;  read_reg_b   = rb;
    if (!rst_n) model_reset();
    exp_q.push_back({(sweep_left > 0), model_read(ra), model_read(rb)});
    chk_valid = 1'b1;
    @(posedge clk);
    if (reset_n) model_edge();
    cyc++;
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ra, rb);
  endtask

  task automatic fill_index_plus_one();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, AW'(i), DW'(i + 1), 1'b0, '0, '0, 1'b0, AW'(i), AW'($urandom_range(0, DEPTH - 1)));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow cyc=%0d no expected entry for presented output", cyc);
      end else begin
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        e = exp_q.pop_front();
        g = {clear_busy, read_data_a, read_data_b};
        if (g === e) n_pass++;
        else $display("FAIL rd_cycle cyc=%0d ra=%0d rb=%0d got busy=%0b a=%h b=%h expected busy=%0b a=%h b=%h",
                      cyc, read_reg_a, read_reg_b, g[EW-1], g[2*DW-1:DW], g[DW-1:0],
                      e[EW-1], e[2*DW-1:DW], e[DW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; chk_valid = 1'b0;
    reset_n = 1'b0; write_enable = 1'b0; write_enable_2 = 1'b0; clear_req = 1'b0;
    write_reg_rd = '0; write_reg_2 = '0; write_data = '0; write_data_2 = '0;
    read_reg_a = '0; read_reg_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Prior contents, then reset: everything reads zero during and after reset.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 1; i < 8; i++)
      step(1'b1, 1'b1, AW'(i), $urandom, 1'b1, AW'(i + 8), $urandom, 1'b0, AW'(i - 1), AW'(i + 7));
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, AW'(2 * i + 1), AW'(2 * i + 9));
    for (int i = 0; i < DEPTH; i += 2) rd(AW'(i), AW'(i + 1));

    // Port-1 write, read next cycle.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 5'd5, 5'd6);
    rd(5'd5, 5'd0);

    // Collision: port 1 wins. Port 2 alone.
    step(1'b1, 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd7, 5'd7);
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd7, 5'd9);
    rd(5'd9, 5'd7);

    // Hardwired zero register on both ports.
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    // Same-cycle write/read of reg 12: bypass or old value, then new value.
    step(1'b1, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, '0, '0, 1'b0, 5'd12, 5'd12);
    rd(5'd12, 5'd5);

    // Full sweep with a write to reg 3 attempted in sweep cycle 10.
    fill_index_plus_one();
    step(1'b1, 1'b1, 5'd20, 32'h0BADF00D, 1'b0, '0, '0, 1'b1, 5'd20, 5'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 10) step(1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 5'd4);
      else rd(5'd3, AW'(k - 1));
    end
    for (int i = 0; i < DEPTH; i += 2) rd(AW'(i), AW'(i + 1));

    // Reset at sweep cycle 12, then a write to reg 4 succeeds on the next edge.
    fill_index_plus_one();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd15, 5'd16);
    for (int k = 1; k < 12; k++) rd(AW'(k + 10), AW'(k - 1));
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd20, 5'd31);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd4, 5'd25);
    step(1'b1, 1'b1, 5'd4, 32'h04040404, 1'b0, '0, '0, 1'b0, 5'd4, 5'd30);
    rd(5'd4, 5'd30);

    // Random traffic with occasional sweeps.
    for (int n = 0; n < 400; n++) begin
      step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3)
                                                                    : $urandom_range(0, DEPTH - 1)),
           $urandom, 1'($urandom_range(0, 60) == 0),
           AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
    end

    chk_valid = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
